enemy_shot: RTL and testbench
=============================

ENEMY_SHOT -- requirements
Module: enemy_shot

Interface
REQ-001 Parameter STEP_DIV, default 500000: clocks per shot movement step.
REQ-002 Parameter SHOT_STEP, default 4: pixels moved down per step.
REQ-003 Parameter COOLDOWN, default 25000000: clocks between end of one shot and the next selection.
REQ-004 Parameter SHIP_Y, default 440; SHIP_W, default 40; SHIP_H, default 20; SCREEN_H, default 480.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high while game state is "playing".
REQ-008 enemy_alive  input  24  alive mask; index = row*8+col, rows 0..2, cols 0..7.
REQ-009 ship_x  input  11  player ship left edge, pixels.
REQ-010 h_counter, v_counter  input  10 each  current VGA pixel coordinate.
REQ-011 shot_active  output  1  enemy shot in flight.
REQ-012 shot_x, shot_y  output  11 each  shot top-left, pixels.
REQ-013 shooter_id  output  5  index of enemy that fired the current/last shot.
REQ-014 player_hit  output  1  one-cycle pulse on shot/ship overlap.
REQ-015 R, G, B  output  8 each  shot pixel colour, zero elsewhere.

Function
REQ-016 States: IDLE (cooldown), SELECT (shooter scan), FLY (shot moving); state register only changes on clk.
REQ-017 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every clock regardless of state, never all-zero.
REQ-018 IDLE: cooldown counter counts COOLDOWN clocks with enable high, then enters SELECT; enable low holds counter at zero.
REQ-019 SELECT entry: scan index = lfsr[4:0], minus 24 if >= 24; scan count = 0.
REQ-020 SELECT, each clock: if enemy_alive[index] then load shot and enter FLY, else index increments with wrap 23->0 and count increments.
REQ-021 SELECT: after 24 failed checks (no enemy alive) return to IDLE, shot_active stays 0, shooter_id unchanged.
REQ-022 Shot load: shooter_id = index; shot_x = 180 + col*80 + 16; shot_y = 40 + row*50 + 32; shot_active = 1; step counter = 0.
REQ-023 FLY: step counter counts 0..STEP_DIV-1; on wrap shot_y increases by SHOT_STEP.
REQ-024 Overlap = shot_y+12 > SHIP_Y and shot_y < SHIP_Y+SHIP_H and shot_x+4 > ship_x and shot_x < ship_x+SHIP_W, evaluated every FLY clock on registered position.
REQ-025 FLY priority per clock: overlap (player_hit=1 for that cycle, shot_active=0, to IDLE) > shot_y >= SCREEN_H (shot_active=0, to IDLE, no hit) > step.
REQ-026 A shooter dying mid-flight does not cancel the shot.
REQ-027 enable low in any state: next clock shot_active=0, player_hit=0, state IDLE, cooldown counter 0.
REQ-028 All arithmetic 11-bit unsigned; shot_y saturates rather than wraps.
REQ-029 R=8'hFF, G=8'h00, B=8'h00 when shot_active and shot_x <= h_counter < shot_x+4 and shot_y <= v_counter < shot_y+12; else all zero; combinational from registers.

Reset
REQ-030 Reset asserted: state IDLE, LFSR = 16'hACE1, all counters 0, shot_active 0, shot_x 0, shot_y 0, shooter_id 0, player_hit 0, R/G/B 0, taking effect without a clock edge.
REQ-031 Reset mid-flight clears the shot immediately; after release the full COOLDOWN elapses before any new shot.

Verification (STEP_DIV=2, COOLDOWN=4 unless noted)
REQ-032 enemy_alive=24'h000001, enable=1, ship_x=400 -> shooter_id=0, shot_x=196, shot_y=72; shot descends 4 px per 2 clocks, clears at shot_y=480, player_hit never asserted.
REQ-033 enemy_alive=24'h800000 -> shooter_id=23, shot_x=756, shot_y=172, regardless of LFSR value.
REQ-034 enemy_alive=0 -> SELECT lasts exactly 24 clocks, returns to IDLE, shot_active stays 0, repeats each cooldown.
REQ-035 enemy_alive=24'h000001, ship_x=176 -> player_hit single-cycle pulse when shot_y=432, shot_active 0 next cycle, new shot after 4 cooldown clocks.
REQ-036 enable dropped at shot_y=100 -> shot_active 0 next clock; reset pulse mid-flight -> outputs cleared asynchronously, LFSR=16'hACE1.
REQ-037 Pixel scan with shot at (196,72): h=196..199, v=72..83 gives R=FF; h=200 or v=84 gives R=G=B=0.

Source files
------------

// File: rtl/enemy_shot.sv
// Enemy shot controller: picks a live shooter at random after a cooldown and drops one
// shot toward the player ship. It reports a ship hit and draws the shot as a red 4x12 box.
module enemy_shot #(
  parameter int unsigned STEP_DIV  = 500000,
  parameter int unsigned SHOT_STEP = 4,
  parameter int unsigned COOLDOWN  = 25000000,
  parameter int unsigned SHIP_Y    = 440,
  parameter int unsigned SHIP_W    = 40,
  parameter int unsigned SHIP_H    = 20,
  parameter int unsigned SCREEN_H  = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] enemy_alive,
  input  logic [10:0] ship_x,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  output logic        shot_active,
  output logic [10:0] shot_x,
  output logic [10:0] shot_y,
  output logic [4:0]  shooter_id,
  output logic        player_hit,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  typedef enum logic [1:0] {StIdle = 2'd0, StSelect = 2'd1, StFly = 2'd2} state_e;

  state_e      state;
  logic [15:0] lfsr;
  logic [31:0] cool_cnt;
  logic [31:0] step_cnt;
  logic [4:0]  scan_idx;
  logic [4:0]  scan_cnt;

  logic        lfsr_fb;
  logic [4:0]  start_idx;
  logic [10:0] load_x;
  logic [10:0] load_y;
  logic [11:0] y_sum;
  logic [10:0] y_step;
  logic        overlap;
  logic        off_screen;
  logic        pix_on;

  always_comb begin
    lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    start_idx = (lfsr[4:0] >= 5'd24) ? lfsr[4:0] - 5'd24 : lfsr[4:0];
    load_x    = 11'd196 + 11'(scan_idx[2:0]) * 11'd80;
    load_y    = 11'd72 + 11'(scan_idx[4:3]) * 11'd50;
    // Widened by one bit so sums near the top of the range cannot wrap.
    y_sum      = {1'b0, shot_y} + 12'(SHOT_STEP);
    y_step     = y_sum[11] ? 11'h7FF : y_sum[10:0];
    overlap    = ({1'b0, shot_y} + 12'd12 > 12'(SHIP_Y)) &&
                 ({1'b0, shot_y} < 12'(SHIP_Y) + 12'(SHIP_H)) &&
                 ({1'b0, shot_x} + 12'd4 > {1'b0, ship_x}) &&
                 ({1'b0, shot_x} < {1'b0, ship_x} + 12'(SHIP_W));
    off_screen = {1'b0, shot_y} >= 12'(SCREEN_H);
    pix_on     = shot_active &&
                 ({2'b0, h_counter} >= {1'b0, shot_x}) &&
                 ({2'b0, h_counter} < {1'b0, shot_x} + 12'd4) &&
                 ({2'b0, v_counter} >= {1'b0, shot_y}) &&
                 ({2'b0, v_counter} < {1'b0, shot_y} + 12'd12);
    R = pix_on ? 8'hFF : 8'h00;
    G = 8'h00;
    B = 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      lfsr        <= 16'hACE1;
      cool_cnt    <= '0;
      step_cnt    <= '0;
      scan_idx    <= '0;
      scan_cnt    <= '0;
      shot_active <= 1'b0;
      shot_x      <= '0;
      shot_y      <= '0;
      shooter_id  <= '0;
      player_hit  <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      player_hit <= 1'b0;
      if (!enable) begin
        state       <= StIdle;
        shot_active <= 1'b0;
        cool_cnt    <= '0;
        step_cnt    <= '0;
      end else begin
        case (state)
          StIdle: begin
            if (cool_cnt + 32'd1 >= 32'(COOLDOWN)) begin
              cool_cnt <= '0;
              scan_idx <= start_idx;
              scan_cnt <= '0;
              state    <= StSelect;
            end else begin
              cool_cnt <= cool_cnt + 32'd1;
            end
          end
          StSelect: begin
            if (enemy_alive[scan_idx]) begin
              shooter_id  <= scan_idx;
              shot_x      <= load_x;
              shot_y      <= load_y;
              shot_active <= 1'b1;
              step_cnt    <= '0;
              state       <= StFly;
            end else if (scan_cnt == 5'd23) begin
              cool_cnt <= '0;
              state    <= StIdle;
            end else begin
              scan_idx <= (scan_idx == 5'd23) ? 5'd0 : scan_idx + 5'd1;
              scan_cnt <= scan_cnt + 5'd1;
            end
          end
          StFly: begin
            // Hit beats leaving the screen, which beats moving.
            if (overlap) begin
              player_hit  <= 1'b1;
              shot_active <= 1'b0;
              cool_cnt    <= '0;
              state       <= StIdle;
            end else if (off_screen) begin
              shot_active <= 1'b0;
              cool_cnt    <= '0;
              state       <= StIdle;
            end else if (step_cnt + 32'd1 >= 32'(STEP_DIV)) begin
              step_cnt <= '0;
              shot_y   <= y_step;
            end else begin
              step_cnt <= step_cnt + 32'd1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enemy_shot.sv
// Directed bench for enemy_shot: expected shots are queued when stimulus is set up and
// compared when the DUT launches them.
module tb_enemy_shot;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [23:0] enemy_alive;
  logic [10:0] ship_x;
  logic [9:0]  h_counter;
  logic [9:0]  v_counter;
  logic        shot_active;
  logic [10:0] shot_x;
  logic [10:0] shot_y;
  logic [4:0]  shooter_id;
  logic        player_hit;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;

  enemy_shot #(
    .STEP_DIV(2),
    .SHOT_STEP(4),
    .COOLDOWN(4),
    .SHIP_Y(440),
    .SHIP_W(40),
    .SHIP_H(20),
    .SCREEN_H(480)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .enemy_alive(enemy_alive),
    .ship_x(ship_x),
    .h_counter(h_counter),
    .v_counter(v_counter),
    .shot_active(shot_active),
    .shot_x(shot_x),
    .shot_y(shot_y),
    .shooter_id(shooter_id),
    .player_hit(player_hit),
    .R(R),
    .G(G),
    .B(B)
  );

  typedef struct {
    logic [31:0] id;
    logic [31:0] x;
    logic [31:0] y;
  } exp_shot_t;

  exp_shot_t sb[$];
  int checks = 0;
  int failures = 0;
  bit hit_seen;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic exp_shot_t shot_for(int idx);
    exp_shot_t e;
    e.id = 32'(idx);
    e.x  = 32'(180 + (idx % 8) * 80 + 16);
    e.y  = 32'(40 + (idx / 8) * 50 + 32);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_launch(input string tag);
    exp_shot_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = shot_active;
    end
    check({tag, "_launch"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    check({tag, "_id"}, 32'(shooter_id), e.id);
    check({tag, "_x"}, 32'(shot_x), e.x);
    check({tag, "_y"}, 32'(shot_y), e.y);
  endtask

  task automatic wait_drop(input string tag);
    bit dropped;
    dropped  = 1'b0;
    hit_seen = 1'b0;
    for (int i = 0; i < 400 && !dropped; i++) begin
      @(negedge clk);
      if (player_hit) hit_seen = 1'b1;
      dropped = !shot_active;
    end
    check({tag, "_drop"}, 32'(dropped), 32'd1);
  endtask

  initial begin
    int n;
    bit bad;
    reset       = 1'b1;
    enable      = 1'b0;
    enemy_alive = 24'h0;
    ship_x      = 11'd400;
    h_counter   = 10'd0;
    v_counter   = 10'd0;

    // Reset state before any clock edge
    #1;
    check("rst_active", 32'(shot_active), 32'd0);
    check("rst_x", 32'(shot_x), 32'd0);
    check("rst_y", 32'(shot_y), 32'd0);
    check("rst_id", 32'(shooter_id), 32'd0);
    check("rst_hit", 32'(player_hit), 32'd0);
    check("rst_rgb", {8'h0, R, G, B}, 32'd0);
    check("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    tick(2);
    reset = 1'b0;

    // Single enemy at index 0, ship out of the way
    enable      = 1'b1;
    enemy_alive = 24'h000001;
    sb.push_back(shot_for(0));
    wait_launch("e0");
    tick(2);
    check("e0_step", 32'(shot_y), 32'd76);
    wait_drop("e0");
    check("e0_final_y", 32'(shot_y), 32'd480);
    check("e0_no_hit", 32'(hit_seen), 32'd0);

    // Only the last enemy alive
    enemy_alive = 24'h800000;
    sb.push_back(shot_for(23));
    wait_launch("e23");
    wait_drop("e23");
    check("e23_no_hit", 32'(hit_seen), 32'd0);

    // No enemies: 24-clock scan then cooldown, repeated
    enemy_alive = 24'h0;
    bad = 1'b0;
    for (int i = 0; i < 50 && dut.state != 2'd1; i++) @(negedge clk);
    check("empty_enter_select", 32'(dut.state), 32'd1);
    n = 0;
    while (dut.state == 2'd1 && n < 100) begin
      if (shot_active) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("empty_select_len", 32'(n), 32'd24);
    n = 0;
    while (dut.state == 2'd0 && n < 100) begin
      if (shot_active) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("empty_idle_len", 32'(n), 32'd4);
    check("empty_reselect", 32'(dut.state), 32'd1);
    check("empty_no_shot", 32'(bad), 32'd0);
    check("empty_id_kept", 32'(shooter_id), 32'd23);

    // Ship under enemy 0 column: hit at y=432
    enemy_alive = 24'h000001;
    ship_x      = 11'd176;
    sb.push_back(shot_for(0));
    wait_launch("hit");
    n = 0;
    while (!player_hit && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("hit_pulse", 32'(player_hit), 32'd1);
    check("hit_y", 32'(shot_y), 32'd432);
    check("hit_active_clr", 32'(shot_active), 32'd0);
    tick(1);
    check("hit_one_cycle", 32'(player_hit), 32'd0);
    tick(2);
    check("hit_cooldown", 32'(dut.state), 32'd0);
    tick(1);
    check("hit_reselect", 32'(dut.state), 32'd1);
    sb.push_back(shot_for(0));
    wait_launch("relaunch");

    // Pixel window around the shot at (196,72)
    h_counter = 10'd196; v_counter = 10'd72; #1;
    check("pix_tl_r", 32'(R), 32'hFF);
    check("pix_tl_gb", {16'h0, G, B}, 32'd0);
    h_counter = 10'd199; v_counter = 10'd83; #1;
    check("pix_br_r", 32'(R), 32'hFF);
    h_counter = 10'd200; v_counter = 10'd72; #1;
    check("pix_h200", {8'h0, R, G, B}, 32'd0);
    h_counter = 10'd196; v_counter = 10'd84; #1;
    check("pix_v84", {8'h0, R, G, B}, 32'd0);
    h_counter = 10'd195; v_counter = 10'd71; #1;
    check("pix_outside", {8'h0, R, G, B}, 32'd0);

    // Enable dropped mid-flight
    n = 0;
    while (shot_y != 11'd100 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("en_reach_100", 32'(shot_y), 32'd100);
    enable = 1'b0;
    tick(1);
    check("en_active_clr", 32'(shot_active), 32'd0);
    check("en_idle", 32'(dut.state), 32'd0);
    check("en_hit_clr", 32'(player_hit), 32'd0);

    // Asynchronous reset mid-flight, then a full cooldown
    enable = 1'b1;
    sb.push_back(shot_for(0));
    wait_launch("pre_rst");
    tick(4);
    #3 reset = 1'b1;
    #1;
    check("arst_active", 32'(shot_active), 32'd0);
    check("arst_xy", {10'h0, shot_x, shot_y}, 32'd0);
    check("arst_id", 32'(shooter_id), 32'd0);
    check("arst_lfsr", 32'(dut.lfsr), 32'hACE1);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dut.state != 2'd0 || shot_active) bad = 1'b1;
    end
    check("arst_cooldown", 32'(bad), 32'd0);
    tick(1);
    check("arst_reselect", 32'(dut.state), 32'd1);
    check("arst_no_shot", 32'(shot_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
